// File: rtl/zynq_mini_panel_io_if.sv
// Front-panel bundle for zynq_mini_panel_io: raw keys in, LEDs and key/mode/duty status out.
// The slave modport is the panel controller; the master modport is the board top or a bench.
interface zynq_mini_panel_io_if #(
  parameter int N_LED    = 4,
  parameter int N_KEY    = 2,
  parameter int PWM_BITS = 8
);
  logic [N_KEY-1:0]    PL_KEY_tri_i;
  logic [N_LED-1:0]    PL_LED_tri_o;
  logic [N_KEY-1:0]    key_state_o;
  logic [N_KEY-1:0]    key_press_o;
  logic [1:0]          mode_o;
  logic [PWM_BITS-1:0] duty_o;

  modport master (
    output PL_KEY_tri_i,
    input  PL_LED_tri_o, key_state_o, key_press_o, mode_o, duty_o
  );

  modport slave (
    input  PL_KEY_tri_i,
    output PL_LED_tri_o, key_state_o, key_press_o, mode_o, duty_o
  );
endinterface

// File: rtl/zynq_mini_panel_io.sv
// Front-panel controller: per-key sync/debounce/press detect, and an OFF/STATIC/BLINK/PWM LED mode FSM.
// Optional key1 auto-repeat is built only when ZYNQ_MINI_KEY_AUTOREPEAT_EN is defined.
module zynq_mini_panel_io #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int N_LED       = 4,
  parameter int N_KEY       = 2,
  parameter int DEBOUNCE_MS = 20,
  parameter int BLINK_HZ    = 2,
  parameter int PWM_BITS    = 8
) (
  input  logic                  PL_CLK_50M,
  input  logic                  PL_RST_N,
  zynq_mini_panel_io_if.slave   panel
);

  localparam int DEB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int HALF_CYC   = CLK_HZ / (2 * BLINK_HZ);
  localparam int DEB_W      = $clog2(DEB_CYCLES + 1);
  localparam int PRE_W      = $clog2(HALF_CYC + 1);

  localparam logic [PWM_BITS-1:0] DUTY_RESET = PWM_BITS'(1) << (PWM_BITS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_STEP  = PWM_BITS'(1) << (PWM_BITS - 3);
  localparam logic [N_LED-1:0]    PAT_RESET  = N_LED'(1);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STATIC = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_PWM    = 2'd3
  } mode_e;

  logic [N_KEY-1:0]    sync1, sync2, key_state, key_press_q, press_vec;
  logic [DEB_W-1:0]    deb_cnt [N_KEY];
  mode_e               mode_q, mode_d;
  logic [N_LED-1:0]    pattern_q, pattern_d, led_q, led_d;
  logic [PWM_BITS-1:0] duty_q, duty_d, pwm_cnt;
  logic [PRE_W-1:0]    pre_cnt;
  logic                blink_phase, pwm_on;

  // Raw keys are active-low; the synchroniser output is 1 = pressed. A press pulse
  // is emitted only on the accepted 0->1 transition of the debounced state.
  always_ff @(posedge PL_CLK_50M or negedge PL_RST_N) begin
    if (!PL_RST_N) begin
      sync1       <= '0;
      sync2       <= '0;
      key_state   <= '0;
      key_press_q <= '0;
      for (int i = 0; i < N_KEY; i++) deb_cnt[i] <= '0;
    end else begin
      sync1       <= ~panel.PL_KEY_tri_i;
      sync2       <= sync1;
      key_press_q <= '0;
      for (int i = 0; i < N_KEY; i++) begin
        if (sync2[i] == key_state[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          key_state[i]   <= ~key_state[i];
          key_press_q[i] <= ~key_state[i];
          deb_cnt[i]     <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

`ifdef ZYNQ_MINI_KEY_AUTOREPEAT_EN
  localparam int REP_FIRST = CLK_HZ / 2;
  localparam int REP_NEXT  = CLK_HZ / 10;
  localparam int REP_W     = $clog2(REP_FIRST + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_armed, rep_pulse;

  // First repeat after the long hold interval, then at the shorter rate; release clears it all.
  always_ff @(posedge PL_CLK_50M or negedge PL_RST_N) begin
    if (!PL_RST_N) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
      rep_pulse <= 1'b0;
    end else if (!key_state[1]) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
      rep_pulse <= 1'b0;
    end else begin
      rep_pulse <= 1'b0;
      if (rep_cnt == (rep_armed ? REP_W'(REP_NEXT - 1) : REP_W'(REP_FIRST - 1))) begin
        rep_pulse <= 1'b1;
        rep_armed <= 1'b1;
        rep_cnt   <= '0;
      end else begin
        rep_cnt <= rep_cnt + REP_W'(1);
      end
    end
  end

  always_comb begin
    press_vec    = key_press_q;
    press_vec[1] = key_press_q[1] | rep_pulse;
  end
`else
  always_comb begin
    press_vec = key_press_q;
  end
`endif

  always_ff @(posedge PL_CLK_50M or negedge PL_RST_N) begin
    if (!PL_RST_N) begin
      mode_q    <= MODE_OFF;
      pattern_q <= PAT_RESET;
      duty_q    <= DUTY_RESET;
    end else begin
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      duty_q    <= duty_d;
    end
  end

  // Key0 has priority: a simultaneous key1 press is dropped.
  always_comb begin
    mode_d    = mode_q;
    pattern_d = pattern_q;
    duty_d    = duty_q;
    if (press_vec[0]) begin
      case (mode_q)
        MODE_OFF:    mode_d = MODE_STATIC;
        MODE_STATIC: mode_d = MODE_BLINK;
        MODE_BLINK:  mode_d = MODE_PWM;
        default:     mode_d = MODE_OFF;
      endcase
    end else if (press_vec[1]) begin
      case (mode_q)
        MODE_STATIC, MODE_BLINK: pattern_d = (pattern_q << 1) | (pattern_q >> (N_LED - 1));
        MODE_PWM:                duty_d    = duty_q + DUTY_STEP;
        default:                 ;
      endcase
    end
  end

  always_ff @(posedge PL_CLK_50M or negedge PL_RST_N) begin
    if (!PL_RST_N) begin
      pre_cnt     <= '0;
      blink_phase <= 1'b0;
      pwm_cnt     <= '0;
      led_q       <= '0;
    end else begin
      if (pre_cnt == PRE_W'(HALF_CYC - 1)) begin
        pre_cnt     <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      led_q   <= led_d;
    end
  end

  assign pwm_on = (pwm_cnt < duty_q);

  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_STATIC: led_d = pattern_q;
      MODE_BLINK:  led_d = pattern_q & {N_LED{blink_phase}};
      MODE_PWM:    led_d = pattern_q & {N_LED{pwm_on}};
      default:     led_d = '0;
    endcase
  end

  assign panel.PL_LED_tri_o = led_q;
  assign panel.key_state_o  = key_state;
  assign panel.key_press_o  = press_vec;
  assign panel.mode_o       = mode_q;
  assign panel.duty_o       = duty_q;

endmodule

// File: doc/zynq_mini_panel_io.md
Name: zynq_mini_panel_io

Overview:
- Parametrised front-panel controller for the Zynq-mini PL: N_KEY raw push-buttons in, N_LED LEDs out.
- Per key: 2-FF synchroniser, debounce counter, press-edge detection.
- Mode state machine drives the LEDs OFF / STATIC / BLINK / PWM-dimmed. Key 0 selects the mode; key 1 edits the pattern or the duty.
- Instantiated in the board top in place of constant LED tie-offs; debounced key state is also exported for PS/GPIO use.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- N_LED, 4, number of LEDs (>=1).
- N_KEY, 2, number of keys (>=2; only keys 0 and 1 control the FSM).
- DEBOUNCE_MS, 20, stable time required before a key state change is accepted; DEB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS.
- BLINK_HZ, 2, blink frequency; half-period HALF_CYC = CLK_HZ/(2*BLINK_HZ) cycles.
- PWM_BITS, 8, PWM counter/duty width (>=3).

Ports:
- PL_CLK_50M  in  1  system clock.
- PL_RST_N  in  1  asynchronous active-low reset.
- PL_KEY_tri_i  in  N_KEY  raw keys, active-low (0 = pressed), asynchronous.
- PL_LED_tri_o  out  N_LED  LED drive, active-high, registered.
- key_state_o  out  N_KEY  debounced pressed state (1 = pressed).
- key_press_o  out  N_KEY  one-cycle pulse per accepted press.
- mode_o  out  2  current mode: 0 OFF, 1 STATIC, 2 BLINK, 3 PWM.
- duty_o  out  PWM_BITS  current PWM duty.

Behaviour:
- Reset, async on PL_RST_N low, all flops:
  - PL_LED_tri_o=0, key_state_o=0, key_press_o=0, mode_o=OFF.
  - duty_o=2^(PWM_BITS-1); pattern=1 (LED0 only).
  - Prescaler, blink_phase, PWM counter and debounce counters all 0.
  - Reset asserted mid-operation aborts everything; no event pulses are produced on release.
- Synchroniser: 2 flops per key; raw is inverted so that 1 = pressed.
- Debounce, per key:
  - Counter clears whenever the synced value equals key_state, else increments.
  - When the counter reaches DEB_CYCLES-1 while still differing, key_state toggles and the counter clears.
  - Latency: a raw change held steady appears on key_state_o DEB_CYCLES+2 cycles later.
  - Glitches shorter than DEB_CYCLES produce no change.
- key_press_o[i]=1 for exactly one cycle: the cycle in which key_state_o[i] goes 0->1. Releases produce no pulse.
- FSM, updated the cycle after key_press_o:
  - key0 press: OFF->STATIC->BLINK->PWM->OFF.
  - key1 press in STATIC/BLINK: pattern rotates left by 1 (MSB wraps to bit 0).
  - key1 press in PWM: duty += 2^(PWM_BITS-3), modulo 2^PWM_BITS (wraps).
  - key1 press in OFF: ignored.
  - key0 and key1 pressed in the same cycle: key0 acts, key1 is discarded.
- Blink: prescaler counts 0..HALF_CYC-1 and runs in all modes; blink_phase toggles on wrap.
- PWM: free-running PWM_BITS counter; pwm_on = (cnt < duty). duty=0 gives always off.
- LED output, registered one cycle after the source state:
  - OFF: 0.
  - STATIC: pattern.
  - BLINK: pattern & {N_LED{blink_phase}}.
  - PWM: pattern & {N_LED{pwm_on}}.

Optional Feature:
- Macro: ZYNQ_MINI_KEY_AUTOREPEAT_EN.
- Defined: while key_state_o[1]=1, after CLK_HZ/2 cycles (500 ms) of continuous hold, key_press_o[1] pulses again every CLK_HZ/10 cycles (100 ms). Each pulse acts as a real key1 press. Release stops repeats immediately and clears the repeat counter.
- Not defined: exactly one press pulse per physical press; no repeat logic is synthesised.

Test Plan:
1. Bench parameters CLK_HZ=1000, DEBOUNCE_MS=4 (DEB_CYCLES=4), BLINK_HZ=50 (HALF_CYC=10), PWM_BITS=4.
2. Reset release -> LED=0000, mode_o=0, duty_o=8; hold key0 low steady -> key_state_o[0]=1 exactly 6 cycles after the change, key_press_o[0] high for 1 cycle, mode_o=1 the next cycle, LED=0001 one cycle later.
3. Bounce: key0 low for 3 cycles then high, repeated 5 times -> no key_state_o change, no key_press_o, mode unchanged.
4. Modes: in STATIC press key1 four times -> LED 0010, 0100, 1000, 0001. In BLINK -> LED alternates pattern/0000 every 10 cycles.
5. PWM mode at reset duty=8 -> LED high 8 of every 16 cycles. Six key1 presses -> duty 10, 12, 14, 0, 2, 4; at duty 0 the LED stays off.
6. Both keys pressed in the same cycle while in STATIC -> mode=BLINK, pattern unchanged. PL_RST_N pulsed low mid-blink -> all outputs back to reset values asynchronously. With ZYNQ_MINI_KEY_AUTOREPEAT_EN, key1 held 1000 cycles -> presses at t0, t0+500, then every 100 cycles (6 pulses).
